hack_rom_loader: RTL and testbench

Boot sequencer for cpu_garage. It holds the Hack CPU in reset and receives a program image as a byte stream (valid/ready, e.g. from a UART receiver). It writes the image word-by-word into the instruction ROM write port, checks an XOR checksum, and releases CPU reset only after a clean load. This replaces the simulation-only forced ROM preload with a synthesizable load path.

---
 rtl/hack_loader_pkg.sv | 22 ++
 rtl/hack_loader_chk.sv | 29 ++
 rtl/hack_rom_loader.sv | 151 +++++++++++++++
 tb/tb_hack_rom_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_loader_pkg.sv
// Shared types and constants for the Hack ROM boot loader.
//   SYNC_BYTE : frame start marker
//   instr_t   : 16-bit Hack instruction word, as written into the ROM
//   state_t   : loader sequencer states
package hack_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned WORD_W    = 16;

    typedef logic [WORD_W-1:0] instr_t;

    typedef enum logic [2:0] {
        SYNC,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/hack_loader_chk.sv
// XOR checksum accumulator for the loader data bytes.
//   Clk     : clock
//   clear   : synchronous clear of the accumulator (wins over enable)
//   enable  : fold data into the accumulator
//   data    : byte to accumulate
//   chk     : received checksum byte to compare against
//   match_c : accumulator equals chk (combinational)
module hack_loader_chk (
    input  logic       Clk,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data,
    input  logic [7:0] chk,
    output logic       match_c
);

    logic [7:0] acc;

    always_ff @(posedge Clk) begin
        if (clear) begin
            acc <= 8'h00;
        end else if (enable) begin
            acc <= acc ^ data;
        end
    end

    assign match_c = (acc == chk);

endmodule

// File: rtl/hack_rom_loader.sv
// Boot sequencer: receives a framed program image over a valid/ready byte
// stream, writes it into the instruction ROM and releases CPU reset only after
// the XOR checksum of the image verifies.
//   Clk, Reset          : clock, synchronous active-high reset
//   rx_valid/rx_data    : incoming byte stream
//   rx_ready            : loader accepts a byte (low only in DONE)
//   reload              : request a new image load (honoured in DONE only)
//   rom_we/addr/wdata   : ROM write port, one-cycle strobe per word
//   cpu_reset           : CPU reset, low only while a verified image is loaded
//   load_done/load_err  : verified image present / last frame rejected
//   word_count          : words written by the current or last frame
module hack_rom_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = hack_loader_pkg::SYNC_BYTE
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    import hack_loader_pkg::*;

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    state_t         state;
    logic [7:0]     len_hi;
    logic [7:0]     data_hi;
    logic [CNT_W-1:0] n_words;

    logic           accept_c;
    logic [15:0]    len_c;
    instr_t         word_c;
    logic           chk_clear_c;
    logic           chk_en_c;
    logic           chk_match_c;

    assign accept_c = rx_valid && rx_ready;
    assign len_c    = {len_hi, rx_data};
    assign word_c   = {data_hi, rx_data};

    // Checksum restarts with each frame and covers only the data bytes.
    assign chk_clear_c = Reset || (accept_c && (state == SYNC) && (rx_data == SYNC_BYTE));
    assign chk_en_c    = accept_c && ((state == DATA_HI) || (state == DATA_LO));

    hack_loader_chk u_chk (
        .Clk     (Clk),
        .clear   (chk_clear_c),
        .enable  (chk_en_c),
        .data    (rx_data),
        .chk     (rx_data),
        .match_c (chk_match_c)
    );

    // Frame sequencer, counters and registered ROM write port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= SYNC;
            rx_ready   <= 1'b1;
            cpu_reset  <= 1'b1;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            len_hi     <= 8'h00;
            data_hi    <= 8'h00;
            n_words    <= '0;
        end else begin
            rom_we <= 1'b0;
            case (state)
                SYNC: begin
                    if (accept_c && (rx_data == SYNC_BYTE)) begin
                        word_count <= '0;
                        state      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept_c) begin
                        len_hi <= rx_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept_c) begin
                        // Length is bounded by the ROM depth so the index never wraps mid-image.
                        if ((len_c == 16'd0) || (32'(len_c) > DEPTH)) begin
                            load_err <= 1'b1;
                            state    <= SYNC;
                        end else begin
                            n_words <= CNT_W'(len_c);
                            state   <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (accept_c) begin
                        data_hi <= rx_data;
                        state   <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (accept_c) begin
                        rom_we     <= 1'b1;
                        rom_addr   <= word_count[ADDR_W-1:0];
                        rom_wdata  <= word_c;
                        word_count <= word_count + CNT_W'(1);
                        state      <= ((word_count + CNT_W'(1)) == n_words) ? CHECK : DATA_HI;
                    end
                end
                CHECK: begin
                    if (accept_c) begin
                        if (chk_match_c) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            load_err  <= 1'b0;
                            cpu_reset <= 1'b0;
                            rx_ready  <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                            state    <= SYNC;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        state     <= SYNC;
                        load_done <= 1'b0;
                        cpu_reset <= 1'b1;
                        rx_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader: a frame-level model predicts the
// expected output snapshot after every accepted byte; a negedge process
// compares all outputs against it each cycle.
module tb_hack_rom_loader;

    localparam int unsigned ADDR_W = 10;

    typedef logic [7:0] u8_t;
    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] data;
        logic [10:0] wc;
        logic        done;
        logic        err;
    } snap_t;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              reload = 1'b0;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    hack_rom_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 Clk = ~Clk;

    int          errors = 0;
    int          checks = 0;
    bit          armed = 1'b0;
    int          we_seen = 0;
    snap_t       cur = '0;
    snap_t       eff[$];
    logic [25:0] wlog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wl(input int i);
        if (i < wlog.size()) return 32'(wlog[i]);
        return 32'hDEAD_BEEF;
    endfunction

    // Cycle compare against the model snapshot.
    always @(negedge Clk) begin
        if (armed) begin
            check("rom_we",     32'(rom_we),     32'(cur.we));
            check("rom_addr",   32'(rom_addr),   32'(cur.addr));
            check("rom_wdata",  32'(rom_wdata),  32'(cur.data));
            check("word_count", 32'(word_count), 32'(cur.wc));
            check("load_done",  32'(load_done),  32'(cur.done));
            check("load_err",   32'(load_err),   32'(cur.err));
            check("cpu_reset",  32'(cpu_reset),  32'(!cur.done));
            check("rx_ready",   32'(rx_ready),   32'(!cur.done));
            if (rom_we === 1'b1) begin
                wlog.push_back({rom_addr, rom_wdata});
                we_seen++;
            end
        end
    end

    // Parse a byte stream at frame level; one snapshot per byte, holding the
    // outputs expected in the cycle after that byte is accepted.
    function automatic void build(input u8_t b[$]);
        snap_t s;
        int    p;
        int    n;
        u8_t   x;
        s = cur;
        s.we = 1'b0;
        p = 0;
        eff.delete();
        while (p < b.size()) begin
            if (b[p] != 8'hA5) begin
                eff.push_back(s); p++;
                continue;
            end
            s.wc = '0; eff.push_back(s); p++;
            if (p >= b.size()) break;
            n = int'(b[p]) * 256; eff.push_back(s); p++;
            if (p >= b.size()) break;
            n += int'(b[p]);
            if (n == 0 || n > 1024) begin
                s.err = 1'b1; eff.push_back(s); p++;
                continue;
            end
            eff.push_back(s); p++;
            x = 8'h00;
            for (int k = 0; k < n; k++) begin
                if (p >= b.size()) break;
                s.we = 1'b0; eff.push_back(s); p++;
                if (p >= b.size()) break;
                s.we = 1'b1; s.addr = 10'(k); s.data = {b[p-1], b[p]}; s.wc = 11'(k + 1);
                eff.push_back(s);
                x ^= b[p-1] ^ b[p];
                p++;
                s.we = 1'b0;
            end
            if (p >= b.size()) break;
            s.we = 1'b0;
            if (b[p] == x) begin s.done = 1'b1; s.err = 1'b0; end
            else s.err = 1'b1;
            eff.push_back(s); p++;
        end
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
        cur.we = 1'b0;
    endtask

    task automatic drive(input u8_t b[$], input int from, input int to, input int gap);
        for (int i = from; i < to; i++) begin
            int g;
            g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
            repeat (g) begin
                rx_valid = 1'b0; rx_data = 8'($urandom); tick();
            end
            rx_valid = 1'b1; rx_data = b[i]; tick();
            cur = eff[i];
        end
        rx_valid = 1'b0;
    endtask

    task automatic send(input u8_t b[$], input int gap);
        build(b);
        drive(b, 0, b.size(), gap);
    endtask

    task automatic do_reset();
        Reset = 1'b1; rx_valid = 1'b0; reload = 1'b0;
        tick();
        cur = '0;
        Reset = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        cur.done = 1'b0;
        reload = 1'b0;
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reload_rx_ready",  32'(rx_ready),  32'd1);
        check("reload_done",      32'(load_done), 32'd0);
    endtask

    function automatic void make_frame(input int n, output u8_t f[$]);
        u8_t         x;
        logic [15:0] w;
        x = 8'h00;
        f.delete();
        f.push_back(8'hA5); f.push_back(8'(n >> 8)); f.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            w = 16'($urandom);
            f.push_back(w[15:8]); f.push_back(w[7:0]);
            x ^= w[15:8] ^ w[7:0];
        end
        f.push_back(x);
    endfunction

    initial begin
        // EC^10^E3^08 = 8'h17
        u8_t basic[$]  = {8'hA5, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hE3, 8'h08, 8'h17};
        u8_t badchk[$] = {8'hA5, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hE3, 8'h08, 8'h00};
        u8_t junk[$]   = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h04, 8'h01};
        u8_t one[$]    = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        u8_t f[$];
        int  s0;

        do_reset();
        armed = 1'b1;
        check("rst_cpu_reset", 32'(cpu_reset),  32'd1);
        check("rst_rom_we",    32'(rom_we),     32'd0);
        check("rst_rom_addr",  32'(rom_addr),   32'd0);
        check("rst_wdata",     32'(rom_wdata),  32'd0);
        check("rst_wc",        32'(word_count), 32'd0);
        check("rst_done",      32'(load_done),  32'd0);
        check("rst_err",       32'(load_err),   32'd0);
        check("rst_ready",     32'(rx_ready),   32'd1);

        // Garbage, zero length and oversize length
        s0 = we_seen;
        send(junk, 1);
        tick();
        check("badlen_err",  32'(load_err),   32'd1);
        check("badlen_nowe", 32'(we_seen - s0), 32'd0);
        check("badlen_cpu",  32'(cpu_reset),  32'd1);

        // Basic two-word load
        wlog.delete();
        send(basic, 0);
        tick();
        check("basic_nwrites", 32'(wlog.size()), 32'd2);
        check("basic_w0",      wl(0), {6'd0, 10'd0, 16'hEC10});
        check("basic_w1",      wl(1), {6'd0, 10'd1, 16'hE308});
        check("basic_done",    32'(load_done),  32'd1);
        check("basic_err",     32'(load_err),   32'd0);
        check("basic_cpu",     32'(cpu_reset),  32'd0);
        check("basic_wc",      32'(word_count), 32'd2);

        // Bytes offered in DONE are ignored
        rx_valid = 1'b1; rx_data = 8'hA5;
        repeat (4) tick();
        rx_valid = 1'b0;
        do_reload();

        // Bad checksum, then recovery
        send(badchk, 1);
        tick();
        check("badchk_err",  32'(load_err),  32'd1);
        check("badchk_done", 32'(load_done), 32'd0);
        check("badchk_cpu",  32'(cpu_reset), 32'd1);
        send(basic, 2);
        tick();
        check("recover_done", 32'(load_done), 32'd1);
        check("recover_err",  32'(load_err),  32'd0);
        do_reload();

        // Reload pulsed in DATA_HI has no effect
        build(one);
        drive(one, 0, 3, 0);
        reload = 1'b1; tick(); reload = 1'b0;
        drive(one, 3, one.size(), 0);
        tick();
        check("one_done",  32'(load_done), 32'd1);
        check("one_wdata", 32'(rom_wdata), 32'h1234);
        do_reload();

        // Reset after three data words, then a fresh load from address 0
        make_frame(5, f);
        build(f);
        drive(f, 0, 9, 2);
        do_reset();
        check("midrst_wc",   32'(word_count), 32'd0);
        check("midrst_cpu",  32'(cpu_reset),  32'd1);
        check("midrst_addr", 32'(rom_addr),   32'd0);
        wlog.delete();
        send(basic, 3);
        tick();
        check("after_rst_w0",   wl(0), {6'd0, 10'd0, 16'hEC10});
        check("after_rst_done", 32'(load_done), 32'd1);
        do_reload();

        // Full-depth image with idle gaps
        make_frame(1024, f);
        s0 = we_seen;
        wlog.delete();
        send(f, 5);
        tick();
        check("full_nwrites", 32'(we_seen - s0), 32'd1024);
        check("full_last",    32'(wl(1023) >> 16), 32'd1023);
        check("full_wc",      32'(word_count), 32'd1024);
        check("full_done",    32'(load_done),  32'd1);
        check("full_cpu",     32'(cpu_reset),  32'd0);

        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
